// File: rtl/tt_um_ac3e_uart_rx.sv
// ----------------------------------------------------------------------------
// tt_um_ac3e_uart_rx
//
// 8N1 UART receiver for the Tiny Tapeout wrapper. A serial frame arriving on
// ui_in[0] is shifted in LSB first. On a good stop bit the byte is published
// on uo_out and the valid flag is raised. A rising edge on ui_in[1]
// acknowledges the byte and clears all status flags.
//
// Ports
//   clk      in   1  clock, all state on the rising edge
//   rst_n    in   1  asynchronous active-low reset
//   ena      in   1  ignored
//   ui_in    in   8  [0] rx serial line (idle high), [1] ack strobe
//   uo_out   out  8  last good received byte
//   uio_in   in   8  ignored
//   uio_out  out  8  [0] valid, [1] frame_err, [2] overrun, [3] busy
//   uio_oe   out  8  constant 8'h0F (low nibble of uio drives the flags)
// ----------------------------------------------------------------------------
module tt_um_ac3e_uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_FULL = CW'(CLKS_PER_BIT - 1);
  // Start bit is re-checked half a bit in, so later samples land mid-bit.
  localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT / 2 - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    shift_q, shift_d;
  logic [7:0]    data_q, data_d;
  logic          valid_q, valid_d;
  logic          ferr_q, ferr_d;
  logic          ovr_q, ovr_d;

  logic [1:0]    rx_sync_q;
  logic [1:0]    ack_sync_q;
  logic          ack_prev_q;
  logic          rx_s;
  logic          ack_pulse;

  logic          unused_ok;
  assign unused_ok = &{1'b0, ena, ui_in[7:2], uio_in};

  // Two-flop synchronizers; rx resets to the idle-high level so reset release
  // never looks like a start edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_sync_q  <= 2'b11;
      ack_sync_q <= 2'b00;
      ack_prev_q <= 1'b0;
    end else begin
      // NOTE: sequential state always uses non-blocking assignments so every
      // flop samples the pre-edge value of its neighbours.
      rx_sync_q  <= {rx_sync_q[0], ui_in[0]};
      ack_sync_q <= {ack_sync_q[0], ui_in[1]};
      ack_prev_q <= ack_sync_q[1];
    end
  end

  assign rx_s      = rx_sync_q[1];
  assign ack_pulse = ack_sync_q[1] & ~ack_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: the shift register and output byte are reset too, so a frame
      // aborted by reset can never surface as a partial byte.
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  always_comb begin
    // NOTE: every next-state signal gets its hold value first; a path that
    // leaves one unassigned would infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = valid_q;
    ferr_d  = ferr_q;
    ovr_d   = ovr_q;

    // Ack is applied first; a stop-bit completion in the same cycle below
    // overrides whichever flags it owns.
    if (ack_pulse) begin
      valid_d = 1'b0;
      ferr_d  = 1'b0;
      ovr_d   = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (!rx_s) begin
          state_d = START;
          cnt_d   = '0;
        end
      end

      START: begin
        if (cnt_q == CNT_HALF) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rx_s ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      DATA: begin
        if (cnt_q == CNT_FULL) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          if (idx_q == 3'd7) begin
            state_d = STOP;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      STOP: begin
        if (cnt_q == CNT_FULL) begin
          // Returning to IDLE mid-stop-bit leaves half a bit of slack for the
          // next start edge.
          cnt_d   = '0;
          state_d = IDLE;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            ferr_d  = 1'b0;
            ovr_d   = valid_q & ~ack_pulse;
          end else begin
            ferr_d = 1'b1;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign uo_out  = data_q;
  assign uio_out = {4'b0000, (state_q != IDLE), ovr_q, ferr_q, valid_q};
  assign uio_oe  = 8'h0F;

endmodule
